// File: rtl/rk_kbd_inject_seq.sv
// Key-injection sequencer: queues paste/autotype key events and plays each one as
// shift lead, key hold, shift trail and gap. Optional live-typing abort: RK_KBD_INJECT_ABORT_EN.
module rk_kbd_inject_seq #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned LEAD_CYCLES = 2000,
    parameter int unsigned HOLD_CYCLES = 20000,
    parameter int unsigned GAP_CYCLES  = 20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [6:0]  ev_code,
    input  logic [2:0]  ev_shift,
    input  logic        live_act,
    output logic [63:0] mtx_o,
    output logic [2:0]  shift_o,
    output logic        busy
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned MAX_LH = (LEAD_CYCLES > HOLD_CYCLES) ? LEAD_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAXC   = (MAX_LH > GAP_CYCLES) ? MAX_LH : GAP_CYCLES;
    localparam int unsigned CW     = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

    localparam logic [CW-1:0] LEAD_LD = CW'(LEAD_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HOLD,
        S_TRAIL,
        S_GAP
    } state_e;

    // Event queue: {code[6:0], shift[2:0]} per entry
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [9:0]    head;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    cur_code_q, cur_code_d;
    logic [63:0]   mtx_q, mtx_d;
    logic [2:0]    shift_q, shift_d;
    logic [63:0]   key_vec;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign ev_ready = ~full;
    assign push     = ev_valid & ~full;
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    assign mtx_o    = mtx_q;
    assign shift_o  = shift_q;
    assign busy     = (state_q != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {ev_code, ev_shift};
        end
    end

    // One-hot matrix bit for the event in flight; rows above 7 are shift-only
    always_comb begin
        key_vec = '0;
        if (cur_code_q[3] == 1'b0) begin
            key_vec[{cur_code_q[2:0], cur_code_q[6:4]}] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_code_d = cur_code_q;
        mtx_d      = mtx_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty && !live_act) begin
                    pop        = 1'b1;
                    cur_code_d = head[9:3];
                    shift_d    = head[2:0];
                    mtx_d      = '0;
                    state_d    = S_LEAD;
                    cnt_d      = LEAD_LD;
                end
            end
            S_LEAD: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                    mtx_d   = key_vec;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_TRAIL;
                    cnt_d   = LEAD_LD;
                    mtx_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_TRAIL: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                    shift_d = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                mtx_d   = '0;
                shift_d = '0;
            end
        endcase

`ifdef RK_KBD_INJECT_ABORT_EN
        // Live typing pre-empts playback; the event is dropped and a full gap follows
        if (live_act && (state_q == S_LEAD || state_q == S_HOLD || state_q == S_TRAIL)) begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
            mtx_d   = '0;
            shift_d = '0;
        end
`endif

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_code_q <= '0;
            mtx_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_code_q <= cur_code_d;
            mtx_q      <= mtx_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_rk_kbd_inject_seq.sv
// Self-checking bench for rk_kbd_inject_seq: directed scenarios plus random traffic
// compared each cycle against a phase-offset model of the injection timeline.
module tb_rk_kbd_inject_seq;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned L     = 2;
    localparam int unsigned H     = 4;
    localparam int unsigned G     = 3;
    localparam int unsigned SH_END = 2 * L + H;
    localparam int unsigned TOTAL  = 2 * L + H + G;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ev_valid;
    logic        ev_ready;
    logic [6:0]  ev_code;
    logic [2:0]  ev_shift;
    logic        live_act;
    logic [63:0] mtx_o;
    logic [2:0]  shift_o;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Model: queued events, and the number of cycles since the current event was popped
    logic [9:0]  m_q[$];
    bit          m_active;
    int unsigned m_ph;
    logic [6:0]  m_code;
    logic [2:0]  m_shift;

    rk_kbd_inject_seq #(
        .FIFO_DEPTH (DEPTH),
        .LEAD_CYCLES(L),
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_code (ev_code),
        .ev_shift(ev_shift),
        .live_act(live_act),
        .mtx_o   (mtx_o),
        .shift_o (shift_o),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_ph     = 0;
        m_code   = '0;
        m_shift  = '0;
    endtask

    // Advance the model across one rising edge using the inputs currently applied
    task automatic model_edge();
        bit          do_push;
        logic [9:0]  e;
        do_push = ev_valid && (m_q.size() != DEPTH);
        if (m_active) begin
`ifdef RK_KBD_INJECT_ABORT_EN
            if (live_act && m_ph < SH_END) begin
                m_ph = SH_END;
            end else begin
                m_ph++;
                if (m_ph == TOTAL) m_active = 1'b0;
            end
`else
            m_ph++;
            if (m_ph == TOTAL) m_active = 1'b0;
`endif
        end else if (m_q.size() != 0 && !live_act) begin
            e        = m_q.pop_front();
            m_code   = e[9:3];
            m_shift  = e[2:0];
            m_active = 1'b1;
            m_ph     = 0;
        end
        if (do_push) m_q.push_back({ev_code, ev_shift});
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] one;
        logic [63:0] exp_mtx;
        logic [2:0]  exp_shift;
        logic        exp_busy;
        logic        exp_ready;
        int unsigned r;
        int unsigned c;
        one       = 64'd1;
        r         = m_code[3:0];
        c         = m_code[6:4];
        exp_shift = (m_active && m_ph < SH_END) ? m_shift : 3'b000;
        exp_mtx   = (m_active && m_ph >= L && m_ph < L + H && r <= 7) ? (one << (r * 8 + c)) : 64'd0;
        exp_busy  = m_active || (m_q.size() != 0);
        exp_ready = (m_q.size() != DEPTH);

        tests++;
        assert (mtx_o === exp_mtx) else begin
            fails++;
            $error("FAIL %s mtx_o got %h expected %h", tag, mtx_o, exp_mtx);
        end
        tests++;
        assert (shift_o === exp_shift) else begin
            fails++;
            $error("FAIL %s shift_o got %b expected %b", tag, shift_o, exp_shift);
        end
        tests++;
        assert (busy === exp_busy) else begin
            fails++;
            $error("FAIL %s busy got %b expected %b", tag, busy, exp_busy);
        end
        tests++;
        assert (ev_ready === exp_ready) else begin
            fails++;
            $error("FAIL %s ev_ready got %b expected %b", tag, ev_ready, exp_ready);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic push_ev(input logic [6:0] code, input logic [2:0] sh, input string tag);
        ev_valid = 1'b1;
        ev_code  = code;
        ev_shift = sh;
        step(tag);
        ev_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        ev_valid = 1'b0;
        ev_code  = '0;
        ev_shift = '0;
        live_act = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        #8;
        reset_n = 1'b1;
        run(2, "idle");

        push_ev(7'h14, 3'b000, "single");
        run(14, "single");

        push_ev(7'h12, 3'b001, "shifted");
        run(14, "shifted");

        push_ev(7'h7F, 3'b100, "shiftonly");
        run(14, "shiftonly");

        // Back-to-back pushes until the queue fills
        ev_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ev_code  = 7'($urandom_range(0, 127));
            ev_shift = 3'($urandom_range(0, 7));
            step("fullq");
        end
        ev_valid = 1'b0;
        run(70, "fullq_drain");

        // Live typing holds off the pop, then releases it
        live_act = 1'b1;
        push_ev(7'h25, 3'b010, "arb_hold");
        run(4, "arb_hold");
        live_act = 1'b0;
        run(5, "arb_release");
        live_act = 1'b1;
        run(3, "arb_midseq");
        live_act = 1'b0;
        run(14, "arb_done");

        // Asynchronous reset in HOLD with events still queued
        ev_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ev_code  = 7'h31 + 7'(i);
            ev_shift = 3'b001;
            step("rst_fill");
        end
        ev_valid = 1'b0;
        for (int i = 0; i < 40 && !(m_active && m_ph >= L && m_ph < L + H); i++) step("rst_wait");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        @(negedge clk);
        reset_n = 1'b1;
        run(3, "rst_after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ev_valid = ($urandom_range(0, 3) == 0);
            ev_code  = 7'($urandom_range(0, 127));
            ev_shift = 3'($urandom_range(0, 7));
            live_act = ($urandom_range(0, 7) == 0);
            step("random");
        end
        ev_valid = 1'b0;
        live_act = 1'b0;
        run(80, "random_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
